// File: rtl/mtimer_pkg.sv
// Shared definitions for the RISC-V machine timer: register offsets, CTRL layout,
// bus FSM states and the registered bus response payload.
package mtimer_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CTRL_W = 2;

    localparam logic [ADDR_W-1:0] MTIME_OFF    = 5'h00;
    localparam logic [ADDR_W-1:0] MTIMECMP_OFF = 5'h08;
    localparam logic [ADDR_W-1:0] CTRL_OFF     = 5'h10;

    localparam int unsigned CNT_EN_BIT = 0;
    localparam int unsigned IRQ_EN_BIT = 1;

    localparam logic [CTRL_W-1:0] CTRL_RESET = 2'b01;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } mtimer_state_t;

    typedef struct packed {
        logic            ack;
        logic            err;
        logic [XLEN-1:0] rdata;
    } mtimer_rsp_t;

endpackage

// File: rtl/machine_timer_if.sv
// Simple peripheral bus between the core-side requester (master) and the machine timer (slave).
interface machine_timer_if;
    import mtimer_pkg::*;

    logic              BUS_REQ;
    logic              BUS_WE;
    logic [ADDR_W-1:0] BUS_ADDR;
    logic [XLEN-1:0]   BUS_WDATA;
    logic [XLEN-1:0]   BUS_RDATA;
    logic              BUS_ACK;
    logic              BUS_ERR;

    modport master (
        output BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA,
        input  BUS_RDATA, BUS_ACK, BUS_ERR
    );

    modport slave (
        input  BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA,
        output BUS_RDATA, BUS_ACK, BUS_ERR
    );

endinterface

// File: rtl/mtimer_prescaler.sv
// 16-bit mtime tick divider: one TICK every PRESCALE_DIV enabled cycles.
// Only instantiated when MTIMER_PRESCALER_EN is defined.
module mtimer_prescaler #(
    parameter int unsigned PRESCALE_DIV = 1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);

    localparam int unsigned      DIV_W    = 16;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;

    // Divider parks at zero while counting is disabled or mtime is rewritten
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (!EN || CLR || (div_q == DIV_LAST)) begin
            div_d = '0;
        end
    end

    assign TICK = EN && (div_q == DIV_LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped RISC-V machine timer (mtime/mtimecmp/CTRL) driving the core TIMER interrupt.
// Define MTIMER_PRESCALER_EN to divide the mtime tick by PRESCALE_DIV; otherwise mtime ticks every cycle.
module machine_timer
    import mtimer_pkg::*;
#(
    parameter int unsigned PRESCALE_DIV = 1,
    parameter int unsigned BASE_OFFSET  = 0
) (
    input  logic           CLK,
    input  logic           RESET,
    machine_timer_if.slave bus,
    output logic           TIMER
);

    localparam logic [ADDR_W-1:0] BASE_LO = ADDR_W'(BASE_OFFSET);

    if ((PRESCALE_DIV < 1) || (PRESCALE_DIV > 65535)) begin : g_div_range
        $error("machine_timer: PRESCALE_DIV must be within 1..65535");
    end

    mtimer_state_t   state_q, state_d;
    mtimer_rsp_t     rsp_q, rsp_d;
    logic [XLEN-1:0] mtime_q, mtime_d;
    logic [XLEN-1:0] mtimecmp_q, mtimecmp_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic            timer_q, timer_d;
    logic [ADDR_W-1:0] addr_c;
    logic            mtime_wr_c;
    logic            tick_c;

`ifdef MTIMER_PRESCALER_EN
    mtimer_prescaler #(
        .PRESCALE_DIV(PRESCALE_DIV)
    ) u_prescaler (
        .CLK  (CLK),
        .RESET(RESET),
        .EN   (ctrl_q[CNT_EN_BIT]),
        .CLR  (mtime_wr_c),
        .TICK (tick_c)
    );
`else
    assign tick_c = 1'b1;
`endif

    assign addr_c = bus.BUS_ADDR + BASE_LO;

    // Bus FSM: accept and execute in IDLE, present the one-cycle response in RESP
    always_comb begin
        state_d    = state_q;
        rsp_d      = '0;
        mtime_wr_c = 1'b0;
        mtimecmp_d = mtimecmp_q;
        ctrl_d     = ctrl_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.BUS_REQ) begin
                    state_d   = ST_RESP;
                    rsp_d.ack = 1'b1;
                    case (addr_c)
                        MTIME_OFF: begin
                            if (bus.BUS_WE) mtime_wr_c  = 1'b1;
                            else            rsp_d.rdata = mtime_q;
                        end
                        MTIMECMP_OFF: begin
                            if (bus.BUS_WE) mtimecmp_d  = bus.BUS_WDATA;
                            else            rsp_d.rdata = mtimecmp_q;
                        end
                        CTRL_OFF: begin
                            if (bus.BUS_WE) ctrl_d      = bus.BUS_WDATA[CTRL_W-1:0];
                            else            rsp_d.rdata = XLEN'(ctrl_q);
                        end
                        default: rsp_d.err = 1'b1;
                    endcase
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A bus write to mtime takes priority over the tick in the same cycle
    always_comb begin
        mtime_d = mtime_q;
        if (mtime_wr_c) begin
            mtime_d = bus.BUS_WDATA;
        end else if (ctrl_q[CNT_EN_BIT] && tick_c) begin
            mtime_d = mtime_q + XLEN'(1);
        end
        timer_d = ctrl_q[IRQ_EN_BIT] && (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            rsp_q      <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            ctrl_q     <= CTRL_RESET;
            timer_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rsp_q      <= rsp_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            timer_q    <= timer_d;
        end
    end

    assign bus.BUS_ACK   = rsp_q.ack;
    assign bus.BUS_ERR   = rsp_q.err;
    assign bus.BUS_RDATA = rsp_q.rdata;
    assign TIMER         = timer_q;

endmodule

// File: tb/tb_machine_timer.sv
// Scoreboard bench for machine_timer: randomized bus traffic against an mtime-as-function-of-time model.
module tb_machine_timer;
    import mtimer_pkg::*;

`ifdef MTIMER_PRESCALER_EN
    localparam int unsigned DIV = 4;
`else
    localparam int unsigned DIV = 1;
`endif

    typedef struct packed {
        logic        err;
        logic [63:0] rdata;
    } exp_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    logic TIMER;

    machine_timer_if bus ();

    machine_timer #(
        .PRESCALE_DIV(DIV),
        .BASE_OFFSET (0)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus),
        .TIMER(TIMER)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t exp_q[$];

    // Reference model: mtime = anchor value + ticks elapsed since the anchor edge
    longint unsigned m_anchor_val;
    longint unsigned m_anchor_cyc;
    logic            m_cnt_en;
    logic            m_irq;
    longint unsigned m_cmp;
    longint unsigned edge_n;
    bit              chk_timer = 1'b0;
    logic            exp_timer = 1'b0;
    logic            prev_ack  = 1'b0;

    function automatic longint unsigned model_mtime(input longint unsigned x);
        if (!m_cnt_en) return m_anchor_val;
        return m_anchor_val + (x - m_anchor_cyc) / 64'(DIV);
    endfunction

    task automatic model_reset();
        m_anchor_val = 0;
        m_anchor_cyc = 0;
        m_cnt_en     = 1'b1;
        m_irq        = 1'b0;
        m_cmp        = '1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    // TIMER after edge X reflects the model state after edge X-1
    always @(posedge CLK) begin
        if (!chk_timer) exp_timer = 1'b0;
        else            exp_timer = m_irq && (model_mtime(edge_n) >= m_cmp);
    end

    always @(negedge CLK) begin
        if (chk_timer) check("timer", 64'(TIMER), 64'(exp_timer));
        if (bus.BUS_ACK) begin
            check("ack_pulse", 64'(prev_ack), 64'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_ack: got ack with no pending request (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_err", 64'(bus.BUS_ERR), 64'(e.err));
                check("rsp_rdata", bus.BUS_RDATA, e.rdata);
            end
        end else begin
            check("idle_rdata", bus.BUS_RDATA, 64'd0);
            check("idle_err", 64'(bus.BUS_ERR), 64'd0);
        end
        prev_ack = bus.BUS_ACK;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic apply_write(input logic [4:0] addr, input logic [63:0] wdata, input longint unsigned a);
        case (addr)
            MTIME_OFF: begin
                m_anchor_val = wdata;
                m_anchor_cyc = a;
            end
            MTIMECMP_OFF: m_cmp = wdata;
            CTRL_OFF: begin
                if (wdata[0] != m_cnt_en) begin
                    m_anchor_val = model_mtime(a);
                    m_anchor_cyc = a;
                    m_cnt_en     = wdata[0];
                end
                m_irq = wdata[1];
            end
            default: ;
        endcase
    endtask

    // Called between edges with the FSM idle; the request is accepted on the next edge
    task automatic bus_xfer(input logic we, input logic [4:0] addr, input logic [63:0] wdata);
        exp_t            e;
        int              cyc;
        longint unsigned acc;
        e.err   = !(addr inside {MTIME_OFF, MTIMECMP_OFF, CTRL_OFF});
        e.rdata = '0;
        if (!we && !e.err) begin
            case (addr)
                MTIME_OFF:    e.rdata = model_mtime(edge_n);
                MTIMECMP_OFF: e.rdata = m_cmp;
                default:      e.rdata = {62'd0, m_irq, m_cnt_en};
            endcase
        end
        exp_q.push_back(e);
        bus.BUS_REQ   = 1'b1;
        bus.BUS_WE    = we;
        bus.BUS_ADDR  = addr;
        bus.BUS_WDATA = wdata;
        cyc = 0;
        do begin
            @(posedge CLK);
            #1;
            cyc++;
        end while (!bus.BUS_ACK && cyc < 8);
        acc = edge_n;
        check("ack_latency", 64'(cyc + 1), 64'd2);
        bus.BUS_REQ = 1'b0;
        if (!bus.BUS_ACK) void'(exp_q.pop_back());
        else if (we) apply_write(addr, wdata, acc);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]      addr;
        logic [63:0]     wdata;
        logic            we;
        int unsigned     r;
        bus.BUS_REQ   = 1'b0;
        bus.BUS_WE    = 1'b0;
        bus.BUS_ADDR  = '0;
        bus.BUS_WDATA = '0;
        model_reset();
        repeat (3) @(negedge CLK);
        check("rst_timer", 64'(TIMER), 64'd0);
        check("rst_ack", 64'(bus.BUS_ACK), 64'd0);
        RESET     = 1'b1;
        chk_timer = 1'b1;

        // Reset values
        bus_xfer(1'b0, MTIME_OFF, '0);
        bus_xfer(1'b0, MTIMECMP_OFF, '0);
        bus_xfer(1'b0, CTRL_OFF, '0);

        // Compare crossing, then re-arm by rewriting mtimecmp
        bus_xfer(1'b1, MTIMECMP_OFF, 64'd10);
        bus_xfer(1'b1, CTRL_OFF, 64'd3);
        idle(int'(12 * DIV));
        check("timer_high", 64'(TIMER), 64'd1);
        bus_xfer(1'b0, MTIME_OFF, '0);
        bus_xfer(1'b1, MTIMECMP_OFF, 64'd100);
        check("timer_drop", 64'(TIMER), 64'd0);
        idle(3);

        // Wrap at 2^64
        bus_xfer(1'b1, MTIMECMP_OFF, '1);
        bus_xfer(1'b1, MTIME_OFF, 64'hFFFF_FFFF_FFFF_FFFE);
        bus_xfer(1'b0, MTIME_OFF, '0);
        idle(int'(4 * DIV));
        bus_xfer(1'b0, MTIME_OFF, '0);

        // Unmapped offsets leave every register alone
        bus_xfer(1'b0, 5'h18, '0);
        bus_xfer(1'b1, 5'h04, 64'd5);
        bus_xfer(1'b0, MTIMECMP_OFF, '0);
        bus_xfer(1'b0, CTRL_OFF, '0);

        // Write to mtime coinciding with a tick; counting disabled and re-enabled
        bus_xfer(1'b1, MTIME_OFF, 64'd50);
        bus_xfer(1'b0, MTIME_OFF, '0);
        bus_xfer(1'b1, CTRL_OFF, 64'hFFFF_FFFF_FFFF_FFF2);
        idle(7);
        bus_xfer(1'b0, MTIME_OFF, '0);
        bus_xfer(1'b0, CTRL_OFF, '0);
        bus_xfer(1'b1, CTRL_OFF, 64'd3);

        // Forty free-running cycles between two reads
        bus_xfer(1'b0, MTIME_OFF, '0);
        idle(40);
        bus_xfer(1'b0, MTIME_OFF, '0);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            r  = $urandom_range(0, 9);
            we = 1'($urandom_range(0, 1));
            if (r < 3) begin
                addr  = MTIME_OFF;
                wdata = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15))
                                                    : 64'($urandom_range(0, 200));
            end else if (r < 6) begin
                addr  = MTIMECMP_OFF;
                wdata = model_mtime(edge_n) + 64'($urandom_range(0, 40)) - 64'd12;
            end else if (r < 8) begin
                addr  = CTRL_OFF;
                wdata = {$urandom, 30'($urandom), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 3) != 0)};
            end else begin
                do addr = 5'($urandom);
                while (addr inside {MTIME_OFF, MTIMECMP_OFF, CTRL_OFF});
                wdata = {$urandom, $urandom};
            end
            bus_xfer(we, addr, wdata);
            idle(int'($urandom_range(0, 4)));
        end

        // Reset in the middle of a pending request
        bus_xfer(1'b1, CTRL_OFF, 64'd3);
        bus_xfer(1'b1, MTIME_OFF, 64'd20);
        bus_xfer(1'b1, MTIMECMP_OFF, 64'd5);
        idle(2);
        check("timer_pre_rst", 64'(TIMER), 64'd1);
        chk_timer     = 1'b0;
        bus.BUS_REQ   = 1'b1;
        bus.BUS_WE    = 1'b1;
        bus.BUS_ADDR  = MTIME_OFF;
        bus.BUS_WDATA = 64'd123;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("midrst_timer", 64'(TIMER), 64'd0);
        check("midrst_ack", 64'(bus.BUS_ACK), 64'd0);
        repeat (2) @(negedge CLK);
        bus.BUS_REQ = 1'b0;
        model_reset();
        @(negedge CLK);
        RESET     = 1'b1;
        chk_timer = 1'b1;
        bus_xfer(1'b0, MTIME_OFF, '0);
        bus_xfer(1'b0, MTIMECMP_OFF, '0);
        bus_xfer(1'b0, CTRL_OFF, '0);

        idle(4);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
